rtx_timer_scan: RTL

//  Per-flow retransmission timer table and timeout initiator for the user-defined congestion-control path.

---
 rtl/rtx_timer_scan.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rtx_timer_scan.sv
// Per-flow retransmission timer table with a round-robin expiry scanner that
// issues one timeout event at a time and reloads the flow from the responder's answer.
module rtx_timer_scan #(
   parameter int FLOW_CNT  = 16,
   parameter int FLOW_ID_W = 4,
   parameter int TIME_W    = 32,
   parameter int TIMER_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [TIME_W-1:0]    now,
   input  logic                 arm_valid,
   input  logic [FLOW_ID_W-1:0] arm_fid,
   input  logic [TIMER_W-1:0]   arm_amnt,
   input  logic                 cancel_valid,
   input  logic [FLOW_ID_W-1:0] cancel_fid,
   output logic                 to_valid,
   output logic [FLOW_ID_W-1:0] to_fid,
   input  logic                 to_ready,
   input  logic                 rsp_valid,
   input  logic [FLOW_ID_W-1:0] rsp_fid,
   input  logic [TIMER_W-1:0]   rsp_amnt,
   output logic [15:0]          to_cnt
);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_s;
   logic [FLOW_ID_W-1:0]   ptr_r;
   logic [FLOW_ID_W-1:0]   ptr_s;
   logic                   to_valid_r;
   logic                   to_valid_s;
   logic [FLOW_ID_W-1:0]   to_fid_r;
   logic [FLOW_ID_W-1:0]   to_fid_s;
   logic [15:0]            to_cnt_r;
   logic [15:0]            to_cnt_s;

   logic [FLOW_CNT-1:0]    active_r;
   logic [FLOW_CNT-1:0]    override_r;
   logic [TIME_W-1:0]      deadline_r [FLOW_CNT];

   logic                   scan_hit_s;
   logic                   detect_s;
   logic                   handshake_s;
   logic                   rsp_take_s;
   logic                   in_flight_s;
   logic [TIME_W-1:0]      arm_deadline_s;
   logic [TIME_W-1:0]      rsp_deadline_s;

   function automatic logic [TIME_W-1:0] zext_amnt(input logic [TIMER_W-1:0] amnt);
      return {{(TIME_W-TIMER_W){1'b0}}, amnt};
   endfunction

   // Wrap-safe: deadline reached when now - deadline lies in the lower half of the time ring.
   function automatic logic is_expired(input logic act,
                                       input logic [TIME_W-1:0] dl,
                                       input logic [TIME_W-1:0] t);
      logic [TIME_W-1:0] diff;
      diff = t - dl;
      return act & ~diff[TIME_W-1];
   endfunction

   // Expiry test of the entry under the scan pointer and candidate deadlines
   always_comb begin
      scan_hit_s     = is_expired(active_r[ptr_r], deadline_r[ptr_r], now);
      arm_deadline_s = now + zext_amnt(arm_amnt);
      rsp_deadline_s = now + zext_amnt(rsp_amnt);
      in_flight_s    = (state_r == ST_ISSUE) || (state_r == ST_WAIT_RSP);
   end

   // Scanner FSM next-state and registered-output next values
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      to_valid_s  = to_valid_r;
      to_fid_s    = to_fid_r;
      to_cnt_s    = to_cnt_r;
      detect_s    = 1'b0;
      handshake_s = 1'b0;
      rsp_take_s  = 1'b0;
      case (state_r)
         ST_SCAN: begin
            if (scan_hit_s) begin
               detect_s   = 1'b1;
               to_fid_s   = ptr_r;
               to_valid_s = 1'b1;
               state_s    = ST_ISSUE;
            end else begin
               ptr_s = ptr_r + FLOW_ID_W'(1);
            end
         end
         ST_ISSUE: begin
            if (to_ready) begin
               handshake_s = 1'b1;
               to_valid_s  = 1'b0;
               to_cnt_s    = to_cnt_r + 16'd1;
               state_s     = ST_WAIT_RSP;
            end else begin
               to_valid_s = 1'b1;
            end
         end
         ST_WAIT_RSP: begin
            if (rsp_valid && (rsp_fid == to_fid_r)) begin
               rsp_take_s = 1'b1;
               ptr_s      = to_fid_r + FLOW_ID_W'(1);
               state_s    = ST_SCAN;
            end else begin
               state_s = ST_WAIT_RSP;
            end
         end
         default: begin
            state_s    = ST_SCAN;
            to_valid_s = 1'b0;
         end
      endcase
   end

   // Scanner state, pointer and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_SCAN;
         ptr_r      <= '0;
         to_valid_r <= 1'b0;
         to_fid_r   <= '0;
         to_cnt_r   <= 16'd0;
      end else begin
         state_r    <= state_s;
         ptr_r      <= ptr_s;
         to_valid_r <= to_valid_s;
         to_fid_r   <= to_fid_s;
         to_cnt_r   <= to_cnt_s;
      end
   end

   // Timer table: later statements win, so arm beats cancel and both beat FSM updates
   always_ff @(posedge clk) begin
      for (int i = 0; i < FLOW_CNT; i++) begin
         if (rst) begin
            active_r[i]   <= 1'b0;
            override_r[i] <= 1'b0;
            deadline_r[i] <= '0;
         end else begin
            if (handshake_s && (to_fid_r == FLOW_ID_W'(i))) begin
               active_r[i] <= 1'b0;
            end
            if (rsp_take_s && (to_fid_r == FLOW_ID_W'(i)) && !override_r[i]
                && (rsp_amnt != {TIMER_W{1'b0}})) begin
               active_r[i]   <= 1'b1;
               deadline_r[i] <= rsp_deadline_s;
            end
            if (cancel_valid && (cancel_fid == FLOW_ID_W'(i))) begin
               active_r[i] <= 1'b0;
            end
            if (arm_valid && (arm_fid == FLOW_ID_W'(i))) begin
               active_r[i]   <= 1'b1;
               deadline_r[i] <= arm_deadline_s;
            end
            // Override marks a datapath touch on the in-flight flow; it lives for one event only.
            if (detect_s && (ptr_r == FLOW_ID_W'(i))) begin
               override_r[i] <= 1'b0;
            end else if (rsp_take_s && (to_fid_r == FLOW_ID_W'(i))) begin
               override_r[i] <= 1'b0;
            end else if (in_flight_s && (to_fid_r == FLOW_ID_W'(i))
                         && ((arm_valid && (arm_fid == FLOW_ID_W'(i)))
                             || (cancel_valid && (cancel_fid == FLOW_ID_W'(i))))) begin
               override_r[i] <= 1'b1;
            end
         end
      end
   end

   assign to_valid = to_valid_r;
   assign to_fid   = to_fid_r;
   assign to_cnt   = to_cnt_r;

endmodule
